// File: rtl/plg_sched.sv
// Round-robin frame scheduler feeding two requester queues into a payload generator.
// Optional WAIT_TX watchdog is enabled by defining PLG_SCHED_TIMEOUT_EN.
module plg_sched #(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned MAX_LEN     = 4095,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [14:0] len0,
  input  logic [14:0] len1,
  input  logic [7:0]  dat0,
  input  logic [7:0]  dat1,
  input  logic        plg_do_vld,
  output logic [1:0]  gnt,
  output logic [1:0]  byte_rd,
  output logic [7:0]  plg_di,
  output logic [14:0] plg_di_num,
  output logic        plg_di_vld,
  output logic [1:0]  done,
  output logic        err_len,
  output logic        timeout
);

  typedef enum logic [2:0] {StIdle, StGrant, StXfer, StWaitTx, StGap} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic [14:0] len_q, len_d;
  logic [14:0] cnt_q, cnt_d;
  logic        seen_hi_q, seen_hi_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  byte_rd_q, byte_rd_d;
  logic [7:0]  plg_di_q, plg_di_d;
  logic [14:0] plg_di_num_q, plg_di_num_d;
  logic        plg_di_vld_q, plg_di_vld_d;
  logic        timeout_pulse;
`ifdef PLG_SCHED_TIMEOUT_EN
  logic [16:0] wd_q, wd_d;
`endif

  logic       pick;
  logic       len_bad;
  logic [1:0] win_oh;
  logic [7:0] dat_sel;

  assign win_oh  = win_q ? 2'b10 : 2'b01;
  assign dat_sel = win_q ? dat1 : dat0;
  assign len_bad = (len_q == 15'd0) || (32'(len_q) > MAX_LEN);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    seen_hi_d     = seen_hi_q;
    gnt_d         = gnt_q;
    byte_rd_d     = byte_rd_q;
    plg_di_num_d  = plg_di_num_q;
    done          = 2'b00;
    err_len       = 1'b0;
    timeout_pulse = 1'b0;
`ifdef PLG_SCHED_TIMEOUT_EN
    wd_d          = wd_q;
`endif
    // Favour the pointed-to requester, fall back to the other one.
    pick = req[ptr_q] ? ptr_q : ~ptr_q;

    // The payload path is a one-cycle registered copy of the pop strobe.
    plg_di_vld_d = |byte_rd_q;
    plg_di_d     = (|byte_rd_q) ? dat_sel : plg_di_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          win_d   = pick;
          len_d   = pick ? len1 : len0;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (len_bad) begin
          err_len = 1'b1;
          done    = win_oh;
          gnt_d   = 2'b00;
          ptr_d   = ~win_q;
          state_d = StIdle;
        end else begin
          plg_di_num_d = len_q;
          byte_rd_d    = win_oh;
          cnt_d        = 15'd0;
          state_d      = StXfer;
        end
      end
      StXfer: begin
        if (cnt_q == len_q - 15'd1) begin
          byte_rd_d = 2'b00;
          cnt_d     = 15'd0;
          seen_hi_d = 1'b0;
`ifdef PLG_SCHED_TIMEOUT_EN
          wd_d      = 17'd0;
`endif
          state_d   = StWaitTx;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      StWaitTx: begin
        if (plg_do_vld) begin
          seen_hi_d = 1'b1;
        end
        if (seen_hi_q && !plg_do_vld) begin
          done    = win_oh;
          cnt_d   = 15'd0;
          state_d = StGap;
        end
`ifdef PLG_SCHED_TIMEOUT_EN
        else if (wd_q == 17'(TIMEOUT_CYC - 1)) begin
          timeout_pulse = 1'b1;
          done          = win_oh;
          cnt_d         = 15'd0;
          state_d       = StGap;
        end else begin
          wd_d = wd_q + 17'd1;
        end
`endif
      end
      StGap: begin
        if (cnt_q == 15'(GAP_CYC - 1)) begin
          gnt_d   = 2'b00;
          ptr_d   = ~win_q;
          cnt_d   = 15'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      win_q        <= 1'b0;
      len_q        <= 15'd0;
      cnt_q        <= 15'd0;
      seen_hi_q    <= 1'b0;
      gnt_q        <= 2'b00;
      byte_rd_q    <= 2'b00;
      plg_di_q     <= 8'd0;
      plg_di_num_q <= 15'd0;
      plg_di_vld_q <= 1'b0;
`ifdef PLG_SCHED_TIMEOUT_EN
      wd_q         <= 17'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      seen_hi_q    <= seen_hi_d;
      gnt_q        <= gnt_d;
      byte_rd_q    <= byte_rd_d;
      plg_di_q     <= plg_di_d;
      plg_di_num_q <= plg_di_num_d;
      plg_di_vld_q <= plg_di_vld_d;
`ifdef PLG_SCHED_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign byte_rd    = byte_rd_q;
  assign plg_di     = plg_di_q;
  assign plg_di_num = plg_di_num_q;
  assign plg_di_vld = plg_di_vld_q;
  assign timeout    = timeout_pulse;

endmodule

// File: tb/tb_plg_sched.sv
// Directed self-checking bench for plg_sched: single frame, alternation, length errors,
// mid-frame reset and the WAIT_TX watchdog (expectations follow PLG_SCHED_TIMEOUT_EN).
module tb_plg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [14:0] len0, len1;
  logic [7:0]  dat0, dat1;
  logic        plg_do_vld;
  logic [1:0]  gnt, byte_rd, done;
  logic [7:0]  plg_di;
  logic [14:0] plg_di_num;
  logic        plg_di_vld, err_len, timeout;

  plg_sched #(
    .GAP_CYC    (4),
    .MAX_LEN    (4095),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .dat0      (dat0),
    .dat1      (dat1),
    .plg_do_vld(plg_do_vld),
    .gnt       (gnt),
    .byte_rd   (byte_rd),
    .plg_di    (plg_di),
    .plg_di_num(plg_di_num),
    .plg_di_vld(plg_di_vld),
    .done      (done),
    .err_len   (err_len),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Requester queues: byte_rd pops the head.
  logic [7:0] fifo0 [0:15];
  logic [7:0] fifo1 [0:15];
  logic [3:0] idx0, idx1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      idx0 <= 4'd0;
      idx1 <= 4'd0;
    end else begin
      if (byte_rd[0]) idx0 <= idx0 + 4'd1;
      if (byte_rd[1]) idx1 <= idx1 + 4'd1;
    end
  end
  assign dat0 = fifo0[idx0];
  assign dat1 = fifo1[idx1];

  int vecs = 0;
  int errs = 0;

  // Generator model and observation state.
  bit         prev_vld;
  int         do_left, do_len;
  int         rd0, rd1, vld_runs, done_cnt, do_hi, done_do_hi, err_cnt, err_done_ok;
  int         to_cnt, to_at, since;
  bit         rd_seen, vld_prev, both;
  logic [1:0] done_last, gnt_prev;
  logic [7:0] bytes [$];
  logic [14:0] nums [$];
  int         grants [$];

  task automatic plg_step();
    if (prev_vld && !plg_di_vld) do_left = do_len;
    prev_vld = plg_di_vld;
    if (do_left > 0) begin
      plg_do_vld = 1'b1;
      do_left--;
    end else begin
      plg_do_vld = 1'b0;
    end
  endtask

  task automatic clear_stats();
    rd0 = 0; rd1 = 0; vld_runs = 0; done_cnt = 0; do_hi = 0; done_do_hi = -1;
    err_cnt = 0; err_done_ok = 0; to_cnt = 0; to_at = -1; since = 0;
    rd_seen = 0; vld_prev = 0; both = 0; done_last = 2'b00; gnt_prev = 2'b00;
    bytes.delete(); nums.delete(); grants.delete();
  endtask

  task automatic sample();
    if (byte_rd[0]) rd0++;
    if (byte_rd[1]) rd1++;
    if (|byte_rd) begin
      rd_seen = 1; since = 0;
    end else if (rd_seen) begin
      since++;
    end
    if (gnt == 2'b11) both = 1;
    if (gnt != 2'b00 && gnt != gnt_prev) grants.push_back(gnt[1] ? 1 : 0);
    gnt_prev = gnt;
    if (plg_di_vld) begin
      bytes.push_back(plg_di);
      nums.push_back(plg_di_num);
      if (!vld_prev) vld_runs++;
    end
    vld_prev = plg_di_vld;
    if (done != 2'b00) begin
      done_cnt++; done_last = done; done_do_hi = do_hi;
    end
    if (plg_do_vld) do_hi++;
    if (err_len) begin
      err_cnt++;
      if (done == 2'b10) err_done_ok++;
    end
    if (timeout) begin
      to_cnt++; to_at = since;
    end
  endtask

  task automatic run(input int max_cyc, input int want_done, output bit hit);
    hit = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      plg_step();
      #1;
      sample();
      if (done_cnt >= want_done) begin
        hit = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; plg_do_vld = 1'b0;
    prev_vld = 0; do_left = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; plg_do_vld = 1'b1; len0 = 15'd3; len1 = 15'd3;
    #3;
    vecs++;
    if ({gnt, byte_rd, done} !== 6'd0) begin
      errs++; $display("FAIL reset_ctl got %b want 0", {gnt, byte_rd, done}); end
    vecs++;
    if ({plg_di, plg_di_num, plg_di_vld, err_len, timeout} !== 26'd0) begin
      errs++; $display("FAIL reset_data got %h want 0",
                       {plg_di, plg_di_num, plg_di_vld, err_len, timeout}); end
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] exp [0:2];
    bit hit;
    exp = '{8'hA1, 8'hB2, 8'hC3};
    do_reset();
    clear_stats();
    fifo0[0] = 8'hA1; fifo0[1] = 8'hB2; fifo0[2] = 8'hC3;
    len0 = 15'd3; do_len = 512; req = 2'b01;
    run(2000, 1, hit);
    req = 2'b00;
    vecs++;
    if (!hit) begin errs++; $display("FAIL single_done got none want done within 2000"); end
    vecs++;
    if (rd0 != 3 || rd1 != 0) begin
      errs++; $display("FAIL single_byte_rd got %0d/%0d want 3/0", rd0, rd1); end
    vecs++;
    if (bytes.size() != 3 || vld_runs != 1) begin
      errs++; $display("FAIL single_vld got %0d bytes %0d runs want 3 1", bytes.size(), vld_runs);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (bytes[i] !== exp[i]) begin
          errs++; $display("FAIL single_byte%0d got %h want %h", i, bytes[i], exp[i]); end
        vecs++;
        if (nums[i] !== 15'd3) begin
          errs++; $display("FAIL single_num%0d got %0d want 3", i, nums[i]); end
      end
    end
    vecs++;
    if (done_last !== 2'b01 || done_do_hi != 512) begin
      errs++; $display("FAIL single_done_fall got %b after %0d hi want 01 after 512",
                       done_last, done_do_hi); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      vecs++;
      if (gnt !== ((k < 4) ? 2'b01 : 2'b00)) begin
        errs++; $display("FAIL single_gap%0d got %b want %b", k, gnt, (k < 4) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp [0:7];
    bit hit;
    exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    do_reset();
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      fifo0[i] = 8'h10 + 8'(i);
      fifo1[i] = 8'h20 + 8'(i);
    end
    len0 = 15'd2; len1 = 15'd2; do_len = 3; req = 2'b11;
    run(400, 4, hit);
    req = 2'b00;
    vecs++;
    if (!hit || grants.size() != 4) begin
      errs++; $display("FAIL alt_count got %0d grants want 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (grants[i] != i % 2) begin
          errs++; $display("FAIL alt_order%0d got %0d want %0d", i, grants[i], i % 2); end
      end
    end
    vecs++;
    if (both) begin errs++; $display("FAIL alt_onehot got gnt=11 want never"); end
    vecs++;
    if (bytes.size() != 8) begin
      errs++; $display("FAIL alt_bytes got %0d want 8", bytes.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vecs++;
        if (bytes[i] !== exp[i]) begin
          errs++; $display("FAIL alt_byte%0d got %h want %h", i, bytes[i], exp[i]); end
      end
    end
  endtask

  task automatic test_err_len();
    logic [14:0] bad [0:1];
    bit hit;
    bad = '{15'd0, 15'd4096};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      clear_stats();
      len1 = bad[t]; do_len = 3; req = 2'b10;
      run(20, 1, hit);
      req = 2'b00;
      @(posedge clk); #2;
      vecs++;
      if (gnt !== 2'b00) begin
        errs++; $display("FAIL err%0d_gnt got %b want 00", t, gnt); end
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #2;
        sample();
      end
      vecs++;
      if (!hit || err_cnt != 1 || err_done_ok != 1 || done_cnt != 1) begin
        errs++; $display("FAIL err%0d_pulse got err=%0d done=%0d paired=%0d want 1 1 1",
                         t, err_cnt, done_cnt, err_done_ok); end
      vecs++;
      if (rd0 + rd1 != 0 || bytes.size() != 0) begin
        errs++; $display("FAIL err%0d_nodata got rd=%0d vld=%0d want 0 0",
                         t, rd0 + rd1, bytes.size()); end
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  hit;
    do_reset();
    clear_stats();
    for (int i = 0; i < 8; i++) fifo0[i] = 8'h40 + 8'(i);
    len0 = 15'd8; do_len = 4; req = 2'b01;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(posedge clk); #2;
      if (byte_rd[0]) n++;
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({gnt, byte_rd, plg_di, plg_di_num, plg_di_vld, done, err_len, timeout} !== 32'd0) begin
      errs++; $display("FAIL midrst_outs got %h want 0",
                       {gnt, byte_rd, plg_di, plg_di_num, plg_di_vld, done, err_len, timeout});
    end
    clear_stats();
    prev_vld = 0; do_left = 0; plg_do_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      sample();
    end
    vecs++;
    if (done_cnt != 0) begin errs++; $display("FAIL midrst_nodone got %0d want 0", done_cnt); end
    rst = 1'b0;
    clear_stats();
    run(200, 1, hit);
    req = 2'b00;
    vecs++;
    if (!hit || done_last !== 2'b01 || rd0 != 8 || bytes.size() != 8) begin
      errs++; $display("FAIL midrst_next got done=%b rd=%0d vld=%0d want 01 8 8",
                       done_last, rd0, bytes.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vecs++;
        if (bytes[i] !== 8'h40 + 8'(i)) begin
          errs++; $display("FAIL midrst_byte%0d got %h want %h", i, bytes[i], 8'h40 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit hit;
    do_reset();
    clear_stats();
    fifo0[0] = 8'h55; fifo0[1] = 8'h66;
    len0 = 15'd2; do_len = 0; req = 2'b01;
`ifdef PLG_SCHED_TIMEOUT_EN
    run(300, 1, hit);
    req = 2'b00;
    vecs++;
    if (!hit || to_cnt != 1 || to_at != 100 || done_last !== 2'b01) begin
      errs++; $display("FAIL timeout_fire got to=%0d at %0d done=%b want 1 at 100 01",
                       to_cnt, to_at, done_last); end
`else
    run(250, 1, hit);
    vecs++;
    if (hit || to_cnt != 0) begin
      errs++; $display("FAIL timeout_off got done=%0d to=%0d want 0 0", done_cnt, to_cnt); end
    vecs++;
    if (gnt !== 2'b01 || rd0 != 2) begin
      errs++; $display("FAIL timeout_stuck got gnt=%b rd=%0d want 01 2", gnt, rd0); end
    req = 2'b00;
`endif
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      fifo0[i] = 8'h00;
      fifo1[i] = 8'h00;
    end
    prev_vld = 0; do_left = 0; do_len = 0;
    test_reset();
    test_single();
    test_alternate();
    test_err_len();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/plg_sched.md
PLG_SCHED -- requirements
Module: plg_sched

Interface
REQ-001 Parameter GAP_CYC, default 4: idle cycles inserted between consecutive frames (1..255).
REQ-002 Parameter MAX_LEN, default 4095: largest accepted frame length in bytes (PLG write address is 12 bits).
REQ-003 Parameter TIMEOUT_CYC, default 65535: watchdog limit in WAIT_TX, used only when PLG_SCHED_TIMEOUT_EN is defined.
REQ-004 One clock; reset is asynchronous and active-high: ports clk and rst.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous reset, active high.
REQ-007 req  input  2  frame request per requester (0 = data queue, 1 = management queue), level, held until done.
REQ-008 len0 / len1  input  15 each  frame length in bytes, stable while req[n] high.
REQ-009 dat0 / dat1  input  8 each  current payload byte of requester n, advanced by byte_rd[n].
REQ-010 plg_do_vld  input  1  serial-output valid returned by the payload generator.
REQ-011 gnt  output  2  one-hot grant, high from GRANT through GAP exit of the granted frame.
REQ-012 byte_rd  output  2  pop strobe to requester n, one per byte.
REQ-013 plg_di  output  8  payload byte to generator.
REQ-014 plg_di_num  output  15  frame length to generator.
REQ-015 plg_di_vld  output  1  byte valid to generator.
REQ-016 done  output  2  one-cycle completion pulse per requester.
REQ-017 err_len  output  1  one-cycle pulse: frame rejected for length.
REQ-018 timeout  output  1  one-cycle pulse: watchdog abort.

Function
REQ-019 FSM states SHALL be IDLE, GRANT, XFER, WAIT_TX, GAP; encoding free.
REQ-020 IDLE: if any req high, SHALL pick winner round-robin (pointer to requester after last served; reset pointer favours req[0]) and go GRANT.
REQ-021 GRANT (1 cycle): SHALL latch len of winner into 15-bit len_q, assert gnt[winner], drive plg_di_num = len_q from next cycle.
REQ-022 GRANT with len_q == 0 or len_q > MAX_LEN: SHALL pulse err_len and done[winner] together, drop gnt, return IDLE, advance pointer.
REQ-023 XFER: byte_rd[winner] SHALL be high exactly len_q consecutive cycles; 15-bit byte counter counts up to len_q-1 then state goes WAIT_TX.
REQ-024 plg_di/plg_di_vld SHALL be registered copies of dat[winner]/byte_rd[winner], one cycle latency; plg_di_vld therefore exactly len_q consecutive cycles, no gaps.
REQ-025 plg_di_num SHALL stay constant from GRANT+1 until WAIT_TX exit.
REQ-026 WAIT_TX: SHALL wait for plg_do_vld rising, then falling; on the falling-edge cycle pulse done[winner] and go GAP.
REQ-027 GAP: SHALL hold GAP_CYC cycles with gnt high, then clear gnt, advance pointer, go IDLE.
REQ-028 req dropping during XFER/WAIT_TX SHALL be ignored; frame completes.
REQ-029 Simultaneous req[0], req[1] in IDLE SHALL be served alternately; one requester alone SHALL be served back-to-back.
REQ-030 plg_do_vld outside WAIT_TX SHALL be ignored.

Reset
REQ-031 rst high SHALL, asynchronously, force IDLE, pointer to requester 0, counters 0, and all outputs (gnt, byte_rd, plg_di, plg_di_num, plg_di_vld, done, err_len, timeout) to 0.
REQ-032 Reset mid-frame SHALL abort with no done pulse; first frame after release follows REQ-020.

Configuration
REQ-033 Macro PLG_SCHED_TIMEOUT_EN defined: WAIT_TX counter SHALL abort after TIMEOUT_CYC cycles without completion, pulse timeout and done[winner] together, go GAP.
REQ-034 Macro undefined: WAIT_TX SHALL wait indefinitely; timeout tied 0; no watchdog logic.

Verification
REQ-035 req=01, len0=3, dat0 bytes A1,B2,C3; PLG returns do_vld 512 cycles -> byte_rd[0] 3 cycles, plg_di_vld 3 cycles A1,B2,C3, plg_di_num=3, done[0] on do_vld fall, gnt[0] low after 4 GAP cycles.
REQ-036 req=11 held, len0=len1=2 -> grant order 0,1,0,1; never both gnt bits high.
REQ-037 req=10, len1=0, then len1=4096 -> err_len+done[1] pulse each, no byte_rd, no plg_di_vld.
REQ-038 rst pulsed at third byte of len0=8 frame -> all outputs 0 immediately, no done; next req frame completes normally.
REQ-039 PLG_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=100, plg_do_vld stuck 0 -> timeout+done[0] at WAIT_TX cycle 100; undefined -> FSM stays WAIT_TX, timeout 0.
